// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller: FSM encoding, widths and the
// leading-zero blank-mask helper used when FND_LEADING_ZERO_BLANK_EN is defined.
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } fnd_state_e;

    localparam int FND_DIGITS    = 4;
    localparam int FND_BIN_W     = 14;
    localparam int FND_BCD_W     = 16;
    localparam int FND_MAX_VALUE = 9999;

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    function automatic logic [FND_DIGITS-1:0] blank_mask(input logic [FND_BCD_W-1:0] bcd);
        logic [FND_DIGITS-1:0] m;
        logic                  nz;
        m  = '0;
        nz = 1'b0;
        for (int i = FND_DIGITS - 1; i > 0; i--) begin
            nz   = nz | (bcd[i*4 +: 4] != 4'd0);
            m[i] = !nz;
        end
        return m;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// FND_BIN_W iterations per conversion; o_done marks the final iteration cycle.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [FND_BIN_W-1:0] i_bin,
    output logic                 o_done,
    output logic [FND_BCD_W-1:0] o_bcd
);

    logic [FND_BCD_W+FND_BIN_W-1:0] r_sr;
    logic [3:0]                     r_cnt;
    logic                           r_busy;
    logic [FND_BCD_W-1:0]           w_adj;

    always_comb begin
        w_adj = r_sr[FND_BIN_W +: FND_BCD_W];
        for (int i = 0; i < FND_DIGITS; i++) begin
            if (r_sr[FND_BIN_W + i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_sr[FND_BIN_W + i*4 +: 4] + 4'd3;
        end
    end

    assign o_done = r_busy && (r_cnt == 4'(FND_BIN_W - 1));
    assign o_bcd  = r_sr[FND_BIN_W +: FND_BCD_W];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_sr   <= {{FND_BCD_W{1'b0}}, i_bin};
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            // The top BCD bit is dropped by the shift; it is always 0 for inputs <= 9999.
            r_sr  <= {w_adj[FND_BCD_W-2:0], r_sr[FND_BIN_W-1:0], 1'b0};
            r_cnt <= r_cnt + 4'd1;
            if (o_done)
                r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Accepts a binary value, converts it to BCD and scans the four digits onto the
// FND decoder. Define FND_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_Valid,
    output logic                 o_Ready,
    input  logic [FND_BIN_W-1:0] i_Value,
    input  logic                 i_En,
    output logic                 o_En,
    output logic [1:0]           o_DigitSelect,
    output logic [3:0]           o_Value,
    output logic                 o_Overflow
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    fnd_state_e           r_state, w_state_nxt;
    logic                 w_start, w_commit, w_done;
    logic                 w_ovf_in;
    logic [FND_BIN_W-1:0] w_clamped;
    logic [FND_BCD_W-1:0] w_bcd;
    logic [FND_BCD_W-1:0] r_display;
    logic [FND_DIGITS-1:0] r_blank;
    logic                 r_ovf_pend;
    logic [PW-1:0]        r_presc;
    logic [1:0]           r_idx, w_idx_nxt;
    logic                 w_wrap;

    assign w_ovf_in  = (i_Value > FND_BIN_W'(FND_MAX_VALUE));
    assign w_clamped = w_ovf_in ? FND_BIN_W'(FND_MAX_VALUE) : i_Value;
    assign o_Ready   = (r_state == ST_IDLE);

    bin2bcd_seq u_bin2bcd (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_start),
        .i_bin   (w_clamped),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_Valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV:   if (w_done) w_state_nxt = ST_COMMIT;
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ovf_pend <= 1'b0;
            r_display  <= '0;
            r_blank    <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (w_start)
                r_ovf_pend <= w_ovf_in;
            if (w_commit) begin
                r_display  <= w_bcd;
                o_Overflow <= r_ovf_pend;
`ifdef FND_LEADING_ZERO_BLANK_EN
                r_blank    <= blank_mask(w_bcd);
`else
                r_blank    <= '0;
`endif
            end
        end
    end

    // Outputs are registered from the next index so o_DigitSelect moves on the wrap edge itself.
    assign w_wrap    = (r_presc == PW'(CLK_DIV - 1));
    assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_presc       <= '0;
            r_idx         <= '0;
            o_DigitSelect <= '0;
            o_Value       <= '0;
            o_En          <= 1'b0;
        end else begin
            r_presc       <= w_wrap ? '0 : r_presc + PW'(1);
            r_idx         <= w_idx_nxt;
            o_DigitSelect <= w_idx_nxt;
            o_Value       <= r_display[{w_idx_nxt, 2'b00} +: 4];
            o_En          <= i_En && !r_blank[w_idx_nxt];
        end
    end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

- **Position:** drives the combinational BCD-to-FND font decoder, which sits directly downstream.
- **Input side:** accepts a 14-bit binary value through a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble engine.
- **Output side:** time-multiplexes the four digits onto the decoder's digit-select/value inputs at a programmable refresh rate.

## Interface
Parameters:
- CLK_DIV, 100000, clock cycles per digit slot (scan period = 4*CLK_DIV); legal range ≥ 2.

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge.
- i_reset  input  1  reset, asynchronous and active-high.
- i_Valid  input  1  new value present on i_Value.
- o_Ready  output  1  block can accept a value.
- i_Value  input  14  unsigned binary value to display.
- i_En  input  1  display enable; passed to the decoder.
- o_En  output  1  enable to the decoder.
- o_DigitSelect  output  2  digit being driven; 0 = ones, 3 = thousands.
- o_Value  output  4  BCD digit for o_DigitSelect.
- o_Overflow  output  1  last committed value exceeded 9999 and was clamped.

## Operation
- **Handshake:** a value is accepted on a rising edge where i_Valid && o_Ready.
  - i_Valid while o_Ready = 0 is ignored; nothing is queued.
- **Clamp:** an accepted value > 9999 is replaced by 9999. An overflow flag is captured alongside it.
- **FSM states:** IDLE, CONV, COMMIT.
  - IDLE → CONV on accept.
  - CONV runs exactly 14 iterations. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts the 30-bit {bcd[15:0], bin[13:0]} register left by 1.
  - CONV → COMMIT after iteration 14.
  - COMMIT writes the 16-bit display register, o_Overflow and the blank mask, then → IDLE.
  - o_Ready = (state == IDLE).
- **Scan:**
  - A prescaler counts 0..CLK_DIV-1 continuously, independent of the FSM and of i_En.
  - On wrap, the digit index increments 3 → 0 → 1 → 2 → 3 → 0 (2-bit wrap).
  - Registered outputs:
    - o_DigitSelect = index.
    - o_Value = display[index*4 +: 4].
    - o_En = i_En && !blank[index].
  - A COMMIT landing mid-slot takes effect on the next output register update. Glitch-free by construction: o_Value is always a complete digit from either the old or the new display register.
- **i_En low:** scanning and conversion continue; o_En = 0.
- **Reset (any time, including mid-conversion):**
  - Conversion is aborted and the FSM goes to IDLE.
  - Display register = 0, blank mask = 0, prescaler = 0, index = 0.
  - Every output is 0, except o_Ready = 1.

## Timing
- **Accept to display:** accept at edge N.
  - CONV occupies edges N+1..N+14.
  - COMMIT at edge N+15 updates the display register.
  - o_Ready = 1 again after edge N+15.
- **Throughput:** one value per 16 cycles.
- **Output latency:** outputs are registered, so they reflect the display register 1 cycle after it changes.
- **Slot length:** each digit slot lasts exactly CLK_DIV cycles. The first index increment is CLK_DIV cycles after reset release.

## Configuration
- FND_LEADING_ZERO_BLANK_EN, defined:
  - COMMIT computes the blank mask. Each digit above the most significant nonzero digit is blanked.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - o_En is 0 during blanked slots.
- FND_LEADING_ZERO_BLANK_EN, undefined: blank mask is constant 0 and all four digits are always shown.

## Structure
- **Shared package fnd_pkg:**
  - FSM state encoding (IDLE, CONV, COMMIT).
  - FND_DIGITS = 4.
  - FND_BIN_W = 14.
  - FND_BCD_W = 16.
  - FND_MAX_VALUE = 9999.
- **Sub-module bin2bcd_seq:** the double-dabble engine.
  - Inputs: start, 14-bit binary.
  - Outputs: done pulse, 16-bit BCD.
  - The FSM lives in fnd_scan_ctrl.
- **Scan prescaler:** stays in the top module.

## Test plan
(All scenarios use CLK_DIV = 4.)
- **Reset:** assert i_reset mid-CONV.
  - During reset: all outputs 0, o_Ready = 1.
  - After release: first index change after 4 cycles.
- **Convert 1234:** i_Value = 1234 accepted.
  - o_Ready low for exactly 15 cycles.
  - Display = 16'h1234.
  - Scan produces (0,4), (1,3), (2,2), (3,1) for (o_DigitSelect, o_Value), 4 cycles each, repeating.
- **Clamp:** i_Value = 12000 → display 16'h9999, o_Overflow = 1. A following i_Value = 5 clears o_Overflow.
- **Busy drop:** i_Valid pulsed with 42, then with 77 during CONV → display 16'h0042. The 77 is dropped.
- **Enable:** i_En = 0 with value 8 → o_En stays 0 while o_DigitSelect still cycles through 0..3.
- **Leading-zero blanking:** with FND_LEADING_ZERO_BLANK_EN, value 7 → o_En = 1 only when o_DigitSelect = 0. Without the macro → o_En = 1 in all slots, and o_Value = 0 in slots 1..3.
